sar_logic: RTL

//   Successive-approximation controller for the SAR ADC. Sits directly upstream of the capacitor DAC array:

---
 rtl/sar_logic.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sar_logic.sv
// Successive-approximation controller: samples, resolves NBITS MSB-first
// through the capacitor DAC bottom plates and hands the code off over a
// valid/ready handshake.
//
// Handshake: result is presented with result_valid=1 and held unchanged
// until a cycle in which result_valid and result_ready are both high; that
// cycle is the transfer. result_valid never drops without a transfer,
// except on rst.
module sar_logic #(
  parameter int NBITS         = 16,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             sample,
  output logic [NBITS-1:0] cap_botplate_m,
  output logic [NBITS-1:0] cap_botplate_d,
  output logic             comp_strobe,
  input  logic             comp_out,
  output logic [NBITS-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [1:0]       dbg_state
);

  localparam int PERIOD = SETTLE_CYCLES + 2;
  localparam int MAX_A  = (SAMPLE_CYCLES > PERIOD) ? SAMPLE_CYCLES : PERIOD;
  localparam int MAX_C  = (MAX_A > NBITS) ? MAX_A : NBITS;
  localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0] PHASE_LAST  = CW'(PERIOD - 1);
  localparam logic [CW-1:0] STROBE_PH   = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] MSB_IDX     = CW'(NBITS - 1);
  localparam logic [NBITS-1:0] MSB_TRIAL = {1'b1, {(NBITS-1){1'b0}}};
  // With no settle time the strobe lands on the first cycle of each bit.
  localparam logic STROBE_AT_C0 = (SETTLE_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state_q, state_n;
  logic [CW-1:0]    cnt_q, cnt_n;      // sample-cycle count, or phase within a bit
  logic [CW-1:0]    bit_q, bit_n;      // bit currently under trial
  logic [NBITS-1:0] m_q, m_n;
  logic [NBITS-1:0] d_q;
  logic [NBITS-1:0] result_q, result_n;
  logic             valid_q, valid_n;
  logic             sample_q, sample_n;
  logic             strobe_q, strobe_n;
  logic             busy_q, busy_n;
  logic [NBITS-1:0] bit_mask, next_mask, resolved;

  // Next-state and next-output computation; every output is registered.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    bit_n     = bit_q;
    m_n       = m_q;
    result_n  = result_q;
    valid_n   = valid_q;
    sample_n  = sample_q;
    strobe_n  = 1'b0;
    busy_n    = busy_q;
    bit_mask  = NBITS'(1) << bit_q;
    next_mask = bit_mask >> 1;
    resolved  = (m_q & ~bit_mask) | (comp_out ? bit_mask : '0);

    unique case (state_q)
      IDLE: begin
        m_n = '0;
        if (start) begin
          state_n  = SAMPLE;
          sample_n = 1'b1;
          busy_n   = 1'b1;
          cnt_n    = '0;
        end
      end
      SAMPLE: begin
        if (cnt_q == SAMPLE_LAST) begin
          state_n  = CONVERT;
          sample_n = 1'b0;
          cnt_n    = '0;
          bit_n    = MSB_IDX;
          m_n      = MSB_TRIAL;
          strobe_n = STROBE_AT_C0;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      CONVERT: begin
        if (cnt_q == PHASE_LAST) begin
          // comp_out is valid in this last phase; commit the bit under trial.
          if (bit_q == '0) begin
            state_n  = DONE;
            m_n      = resolved;
            result_n = resolved;
            valid_n  = 1'b1;
            busy_n   = 1'b0;
          end else begin
            bit_n    = bit_q - CW'(1);
            m_n      = resolved | next_mask;
            cnt_n    = '0;
            strobe_n = STROBE_AT_C0;
          end
        end else begin
          cnt_n    = cnt_q + CW'(1);
          strobe_n = ((cnt_q + CW'(1)) == STROBE_PH);
        end
      end
      DONE: begin
        if (result_ready) begin
          valid_n = 1'b0;
          m_n     = '0;
          if (start) begin
            state_n  = SAMPLE;
            sample_n = 1'b1;
            busy_n   = 1'b1;
            cnt_n    = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        m_n     = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      m_q      <= '0;
      d_q      <= '1;
      result_q <= '0;
      valid_q  <= 1'b0;
      sample_q <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      bit_q    <= bit_n;
      m_q      <= m_n;
      d_q      <= ~m_n;
      result_q <= result_n;
      valid_q  <= valid_n;
      sample_q <= sample_n;
      strobe_q <= strobe_n;
      busy_q   <= busy_n;
    end
  end

  assign busy           = busy_q;
  assign sample         = sample_q;
  assign cap_botplate_m = m_q;
  assign cap_botplate_d = d_q;
  assign comp_strobe    = strobe_q;
  assign result         = result_q;
  assign result_valid   = valid_q;
  assign dbg_state      = state_q;

endmodule
